// File: rtl/lib_resp_checker.sv
// ---------------------------------------------------------------------------
// lib_resp_checker
//
// Purpose:
//   Self-checking harness for a small logic-gate library.
//   Each accepted vector carries:
//     - two stimulus operands (a, b) and a mux select (sel);
//     - the responses of four gates under test (AND, OR, NOT of a, MUX).
//   The vector is registered into a single compare stage. On the next edge,
//   expected values are recomputed from the registered operands and compared
//   with the registered responses. The checker counts vectors and failing
//   vectors, and reports pass/fail when the run completes.
//
// Parameters:
//   WIDTH  - operand and gate-output width
//   CNT_W  - width of vec_count / err_count / fail_index (saturating)
//
// Ports:
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   start, stop       - begin/restart a run; end the run after draining
//   in_valid/in_ready - vector handshake (ready only while running)
//   a, b, sel         - stimulus applied to the gates
//   and_out, or_out,
//   not_out, mux_out  - gate responses under test
//   busy, done, pass  - run status (pass = done with zero errors)
//   vec_count         - vectors checked in this run
//   err_count         - vectors with at least one mismatching gate
//   fail_index        - 0-based index of the first failing vector
//   fail_mask         - failing gates of that vector, bits {mux,not,or,and}
//
// Configuration:
//   LIBCHK_FAIL_CAPTURE_EN - when defined, first-failure capture registers
//                            drive fail_index / fail_mask; otherwise both
//                            outputs are tied to zero.
// ---------------------------------------------------------------------------
module lib_resp_checker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic [WIDTH-1:0] and_out,
    input  logic [WIDTH-1:0] or_out,
    input  logic [WIDTH-1:0] not_out,
    input  logic [WIDTH-1:0] mux_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] fail_index,
    output logic [3:0]       fail_mask
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, next_state;

    logic             clear_run;
    logic             accept;

    // Compare stage: a registered copy of the accepted vector.
    logic             stg_valid;
    logic [WIDTH-1:0] stg_a, stg_b;
    logic             stg_sel;
    logic [WIDTH-1:0] stg_and, stg_or, stg_not, stg_mux;

    logic [3:0]       gate_err;
    logic             any_err;

    // The state register. Reset drops the run immediately, independent of
    // the clock, so anything in flight is simply discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and status decode.
    // - A start is only honoured from IDLE or DONE.
    // - In RUN, stop wins over start.
    // - DRAIN waits until the compare stage has emptied, so a vector
    //   accepted on the same edge as stop is still counted before DONE.
    // clear_run marks the edge on which a fresh run begins.
    always_comb begin
        next_state = state;
        clear_run  = 1'b0;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    clear_run  = 1'b1;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (stop) next_state = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!stg_valid) next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    next_state = RUN;
                    clear_run  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Capture the accepted vector. The valid flag lives for exactly one
    // cycle per vector, which gives the counters their one-edge latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= 1'b0;
            stg_a     <= '0;
            stg_b     <= '0;
            stg_sel   <= 1'b0;
            stg_and   <= '0;
            stg_or    <= '0;
            stg_not   <= '0;
            stg_mux   <= '0;
        end else begin
            stg_valid <= accept;
            if (accept) begin
                stg_a   <= a;
                stg_b   <= b;
                stg_sel <= sel;
                stg_and <= and_out;
                stg_or  <= or_out;
                stg_not <= not_out;
                stg_mux <= mux_out;
            end
        end
    end

    // Reference model of the gates, evaluated against the registered
    // responses. Bit order matches fail_mask: {mux, not, or, and}.
    always_comb begin
        gate_err[0] = (stg_and != (stg_a & stg_b));
        gate_err[1] = (stg_or  != (stg_a | stg_b));
        gate_err[2] = (stg_not != ~stg_a);
        gate_err[3] = (stg_mux != (stg_sel ? stg_b : stg_a));
        any_err     = |gate_err;
    end

    // Saturating vector and error counters. They are cleared on the edge
    // that starts a run, and are otherwise stepped once per compared vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_count <= '0;
            err_count <= '0;
        end else if (clear_run) begin
            vec_count <= '0;
            err_count <= '0;
        end else if (stg_valid) begin
            if (vec_count != {CNT_W{1'b1}})
                vec_count <= vec_count + 1'b1;
            if (any_err && (err_count != {CNT_W{1'b1}}))
                err_count <= err_count + 1'b1;
        end
    end

    assign pass = (state == DONE) && (err_count == '0);

`ifdef LIBCHK_FAIL_CAPTURE_EN
    // First-failure capture. A zero error count identifies the first
    // mismatch of the run, and vec_count still holds that vector's 0-based
    // index. The counter saturates rather than wrapping, so it never returns
    // to zero and the capture fires at most once per run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_index <= '0;
            fail_mask  <= '0;
        end else if (clear_run) begin
            fail_index <= '0;
            fail_mask  <= '0;
        end else if (stg_valid && any_err && (err_count == '0)) begin
            fail_index <= vec_count;
            fail_mask  <= gate_err;
        end
    end
`else
    assign fail_index = '0;
    assign fail_mask  = '0;
`endif

endmodule
